// File: rtl/book_mem_arbiter.sv
// Shared order-book RAM stage: captures one-cycle requests from the add/cancel/execute
// engines, serves them round-robin one at a time, and pulses valid back to the owner.
module book_mem_arbiter #(
  parameter int NUM_REQ       = 3,
  parameter int ADDRESS_INDEX = 3,
  parameter int MAX_INDEX     = 11,
  parameter int DEPTH         = MAX_INDEX + 1,
  parameter int RD_LATENCY    = 2,
  parameter int PRICE_W       = 16,
  parameter int QTY_W         = 16
) (
  input  logic                                    clk_in,
  input  logic                                    rst_in,
  input  logic [NUM_REQ-1:0]                      mem_start,
  input  logic [NUM_REQ-1:0][ADDRESS_INDEX:0]     addr,
  input  logic [NUM_REQ-1:0]                      is_write,
  input  logic [NUM_REQ-1:0][PRICE_W+QTY_W-1:0]   data_w,
  output logic [NUM_REQ-1:0]                      valid,
  output logic [PRICE_W+QTY_W-1:0]                data_r,
  output logic                                    addr_err,
  output logic                                    busy
);

  localparam int AW = ADDRESS_INDEX + 1;
  localparam int EW = PRICE_W + QTY_W;
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam int RW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESPOND
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [GW-1:0]   r_ptr;
  logic [GW-1:0]   r_grant;
  logic [CW-1:0]   r_cnt;
  logic [EW-1:0]   r_ram [DEPTH];

  logic [NUM_REQ-1:0] w_pending;
  logic [AW-1:0]      w_slot_addr [NUM_REQ];
  logic [NUM_REQ-1:0] w_slot_wr;
  logic [EW-1:0]      w_slot_data [NUM_REQ];

  logic          w_any;
  logic [GW-1:0] w_pick;
  logic          w_grant_fire;
  logic [AW-1:0] w_cur_addr;
  logic          w_cur_wr;
  logic [EW-1:0] w_cur_data;
  logic          w_in_range;
  logic [RW-1:0] w_ram_idx;
  logic          w_access_first;
  logic          w_access_last;

  function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] base_i, input int k);
    int s;
    s = int'(base_i) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return GW'(s);
  endfunction

  // Per-requester slot; a pulse is dropped while the slot is pending or in flight.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    logic          r_pend;
    logic [AW-1:0] r_addr;
    logic          r_wr;
    logic [EW-1:0] r_data;
    logic          w_capture;

    assign w_capture = mem_start[gi] && !r_pend &&
                       !((r_state != S_IDLE) && (r_grant == GW'(gi)));

    always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
        r_pend <= 1'b0;
      end else if (w_capture) begin
        r_pend <= 1'b1;
      end else if (w_grant_fire && (w_pick == GW'(gi))) begin
        r_pend <= 1'b0;
      end
    end

    always_ff @(posedge clk_in) begin
      if (w_capture) begin
        r_addr <= addr[gi];
        r_wr   <= is_write[gi];
        r_data <= data_w[gi];
      end
    end

    assign w_pending[gi]   = r_pend;
    assign w_slot_addr[gi] = r_addr;
    assign w_slot_wr[gi]   = r_wr;
    assign w_slot_data[gi] = r_data;
  end

  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_any && w_pending[rr_idx(r_ptr, k)]) begin
        w_any  = 1'b1;
        w_pick = rr_idx(r_ptr, k);
      end
    end
  end

  assign w_grant_fire   = (r_state == S_IDLE) && w_any;
  assign w_cur_addr     = w_slot_addr[r_grant];
  assign w_cur_wr       = w_slot_wr[r_grant];
  assign w_cur_data     = w_slot_data[r_grant];
  assign w_in_range     = int'(w_cur_addr) < DEPTH;
  assign w_ram_idx      = RW'(w_cur_addr);
  assign w_access_first = (r_state == S_ACCESS) && (r_cnt == CW'(RD_LATENCY - 1));
  assign w_access_last  = (r_state == S_ACCESS) && (r_cnt == '0);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    valid        = '0;
    addr_err     = 1'b0;
    busy         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) w_state_next = S_ACCESS;
      end
      S_ACCESS: begin
        busy = 1'b1;
        if (r_cnt == '0) w_state_next = S_RESPOND;
      end
      S_RESPOND: begin
        busy     = 1'b1;
        addr_err = !w_in_range;
        for (int k = 0; k < NUM_REQ; k++) valid[k] = (r_grant == GW'(k));
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_ptr   <= '0;
      r_grant <= '0;
      r_cnt   <= '0;
      data_r  <= '0;
    end else begin
      if (w_grant_fire) begin
        r_grant <= w_pick;
        r_ptr   <= (w_pick == GW'(NUM_REQ - 1)) ? '0 : w_pick + GW'(1);
        r_cnt   <= CW'(RD_LATENCY - 1);
      end else if ((r_state == S_ACCESS) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CW'(1);
      end
      // Out-of-range reads return zero rather than an aliased word.
      if (w_access_last && !w_cur_wr) begin
        data_r <= w_in_range ? r_ram[w_ram_idx] : '0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_access_first && w_cur_wr && w_in_range) begin
      r_ram[w_ram_idx] <= w_cur_data;
    end
  end

endmodule

// File: tb/tb_book_mem_arbiter.sv
// Directed bench for book_mem_arbiter: latency, round-robin order, range errors,
// duplicate pulses and asynchronous reset, each scenario in its own task.
module tb_book_mem_arbiter;

  localparam int NR    = 3;
  localparam int AW    = 4;
  localparam int EW    = 32;
  localparam int DEPTH = 12;
  localparam int LAT   = 4;

  logic                   clk_in = 1'b0;
  logic                   rst_in;
  logic [NR-1:0]          mem_start;
  logic [NR-1:0][AW-1:0]  addr;
  logic [NR-1:0]          is_write;
  logic [NR-1:0][EW-1:0]  data_w;
  logic [NR-1:0]          valid;
  logic [EW-1:0]          data_r;
  logic                   addr_err;
  logic                   busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int base   = 0;

  int            q_cyc[$];
  logic [NR-1:0] q_mask[$];
  logic [EW-1:0] q_data[$];
  logic          q_err[$];

  book_mem_arbiter #(
    .NUM_REQ(NR), .ADDRESS_INDEX(AW-1), .MAX_INDEX(DEPTH-1), .DEPTH(DEPTH), .RD_LATENCY(2)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .mem_start(mem_start), .addr(addr),
    .is_write(is_write), .data_w(data_w), .valid(valid), .data_r(data_r),
    .addr_err(addr_err), .busy(busy)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) begin
    if (valid !== '0) begin
      q_cyc.push_back(cyc - base);
      q_mask.push_back(valid);
      q_data.push_back(data_r);
      q_err.push_back(addr_err);
    end
  end

  function automatic logic [EW-1:0] fill_val(input int a);
    return {16'(a * 7 + 200), 16'(a + 1)};
  endfunction

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear_q;
    q_cyc.delete();
    q_mask.delete();
    q_data.delete();
    q_err.delete();
  endtask

  task automatic drive(input int r, input int a, input logic w, input logic [EW-1:0] d);
    addr[r]      = AW'(a);
    is_write[r]  = w;
    data_w[r]    = d;
    mem_start[r] = 1'b1;
  endtask

  task automatic do_op(input int r, input int a, input logic w, input logic [EW-1:0] d,
                       output int lat, output logic [NR-1:0] m, output logic [EW-1:0] rd,
                       output logic e);
    clear_q;
    drive(r, a, w, d);
    base = cyc;
    tick;
    mem_start = '0;
    lat = -1; m = '0; rd = '0; e = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (q_cyc.size() > 0) break;
      tick;
    end
    if (q_cyc.size() > 0) begin
      lat = q_cyc[0]; m = q_mask[0]; rd = q_data[0]; e = q_err[0];
    end
  endtask

  task automatic test_reset;
    rst_in = 1'b1; mem_start = '0; addr = '0; is_write = '0; data_w = '0;
    tick; tick;
    checks++; if (valid !== '0) begin errors++; $display("FAIL reset_valid: got %b expected 000", valid); end
    checks++; if (data_r !== '0) begin errors++; $display("FAIL reset_data_r: got %h expected 0", data_r); end
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL reset_addr_err: got %b expected 0", addr_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst_in = 1'b0;
    tick;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_fill;
    int lat; logic [NR-1:0] m; logic [EW-1:0] rd; logic e;
    for (int a = 0; a < DEPTH; a++) begin
      do_op(0, a, 1'b1, fill_val(a), lat, m, rd, e);
      checks++;
      if (lat !== LAT || m !== 3'b001 || e !== 1'b0) begin
        errors++; $display("FAIL fill_%0d: lat %0d mask %b err %b expected lat 4 mask 001 err 0", a, lat, m, e);
      end
      $display("fill addr %0d lat %0d", a, lat);
    end
  endtask

  task automatic test_write_read;
    int lat; logic [NR-1:0] m; logic [EW-1:0] rd; logic e;
    do_op(0, 3, 1'b1, {16'd100, 16'd5}, lat, m, rd, e);
    checks++; if (lat !== LAT || m !== 3'b001) begin errors++; $display("FAIL wr_latency: lat %0d mask %b expected 4 001", lat, m); end
    checks++; if (rd !== '0) begin errors++; $display("FAIL wr_holds_data_r: got %h expected 0", rd); end
    do_op(0, 3, 1'b0, '0, lat, m, rd, e);
    checks++; if (lat !== LAT || m !== 3'b001) begin errors++; $display("FAIL rd_latency: lat %0d mask %b expected 4 001", lat, m); end
    checks++; if (rd !== {16'd100, 16'd5} || e !== 1'b0) begin errors++; $display("FAIL rd_after_wr: got %h err %b expected 00640005 err 0", rd, e); end
    $display("write/read addr 3 data %h", rd);
  endtask

  task automatic test_contention;
    rst_in = 1'b1; tick; rst_in = 1'b0;
    clear_q;
    drive(0, 0, 1'b0, '0); drive(1, 1, 1'b0, '0); drive(2, 2, 1'b0, '0);
    base = cyc; tick; mem_start = '0;
    repeat (14) tick;
    checks++; if (q_cyc.size() !== 3) begin errors++; $display("FAIL contention_count: got %0d expected 3", q_cyc.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (q_cyc[i] !== 4 + 4 * i || q_mask[i] !== NR'(1 << i) || q_data[i] !== fill_val(i)) begin
        errors++;
        $display("FAIL contention_%0d: cyc %0d mask %b data %h expected cyc %0d mask %b data %h",
                 i, q_cyc[i], q_mask[i], q_data[i], 4 + 4 * i, NR'(1 << i), fill_val(i));
      end
      $display("contention grant %0d at cycle %0d", i, q_cyc[i]);
    end
    // Pointer back at 0: req0 must beat req1 when both arrive together.
    clear_q;
    drive(1, 5, 1'b0, '0); drive(0, 6, 1'b0, '0);
    base = cyc; tick; mem_start = '0;
    repeat (10) tick;
    checks++;
    if (q_cyc.size() !== 2 || q_mask[0] !== 3'b001 || q_cyc[0] !== 4 || q_mask[1] !== 3'b010 || q_cyc[1] !== 8) begin
      errors++;
      $display("FAIL pointer_wrap: n %0d first %b@%0d second %b@%0d expected 001@4 010@8",
               q_cyc.size(), q_mask[0], q_cyc[0], q_mask[1], q_cyc[1]);
    end
    $display("pointer wrap first mask %b", q_mask[0]);
  endtask

  task automatic test_fairness;
    int done;
    logic [NR-1:0] exp_mask [4];
    exp_mask = '{3'b001, 3'b010, 3'b001, 3'b010};
    done = 0;
    clear_q;
    drive(0, 7, 1'b0, '0); drive(1, 8, 1'b0, '0);
    base = cyc; tick; mem_start = '0;
    for (int c = 0; c < 40 && q_cyc.size() < 4; c++) begin
      for (; done < q_cyc.size(); done++) mem_start = mem_start | q_mask[done];
      tick;
      mem_start = '0;
    end
    repeat (12) tick;
    checks++; if (q_cyc.size() < 4) begin errors++; $display("FAIL fair_count: got %0d expected at least 4", q_cyc.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (q_mask[i] !== exp_mask[i] || q_cyc[i] !== 4 + 4 * i) begin
        errors++;
        $display("FAIL fair_%0d: mask %b cyc %0d expected mask %b cyc %0d", i, q_mask[i], q_cyc[i], exp_mask[i], 4 + 4 * i);
      end
      $display("fairness grant %0d mask %b cycle %0d", i, q_mask[i], q_cyc[i]);
    end
  endtask

  task automatic test_out_of_range;
    int lat; logic [NR-1:0] m; logic [EW-1:0] rd; logic e;
    do_op(2, 1, 1'b0, '0, lat, m, rd, e);
    checks++; if (rd !== fill_val(1) || e !== 1'b0 || m !== 3'b100) begin errors++; $display("FAIL oor_pre_read: data %h err %b mask %b expected %h 0 100", rd, e, m, fill_val(1)); end
    do_op(2, DEPTH, 1'b1, 32'hDEAD_BEEF, lat, m, rd, e);
    checks++; if (lat !== LAT || m !== 3'b100 || e !== 1'b1) begin errors++; $display("FAIL oor_write: lat %0d mask %b err %b expected 4 100 1", lat, m, e); end
    checks++; if (rd !== fill_val(1)) begin errors++; $display("FAIL oor_write_holds: data %h expected %h", rd, fill_val(1)); end
    do_op(2, DEPTH, 1'b0, '0, lat, m, rd, e);
    checks++; if (lat !== LAT || m !== 3'b100 || e !== 1'b1 || rd !== '0) begin errors++; $display("FAIL oor_read: lat %0d mask %b err %b data %h expected 4 100 1 0", lat, m, e, rd); end
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL oor_err_pulse: got %b expected 0 after respond", addr_err); end
    $display("out-of-range read data %h err %b", rd, e);
  endtask

  task automatic test_duplicate;
    clear_q;
    drive(1, 5, 1'b0, '0);
    base = cyc; tick;
    addr[1] = AW'(6); mem_start[1] = 1'b1;
    tick; mem_start = '0;
    repeat (12) tick;
    checks++;
    if (q_cyc.size() !== 1 || q_mask[0] !== 3'b010 || q_cyc[0] !== 4 || q_data[0] !== fill_val(5)) begin
      errors++;
      $display("FAIL duplicate: n %0d mask %b cyc %0d data %h expected 1 010 4 %h",
               q_cyc.size(), q_mask[0], q_cyc[0], q_data[0], fill_val(5));
    end
    $display("duplicate pulse served %0d time(s) data %h", q_cyc.size(), q_data[0]);
  endtask

  task automatic test_reset_mid_access;
    int lat; logic [NR-1:0] m; logic [EW-1:0] rd; logic e;
    clear_q;
    drive(0, 4, 1'b0, '0);
    base = cyc; tick; mem_start = '0;
    tick;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b expected 1", busy); end
    rst_in = 1'b1;
    #1;
    checks++;
    if (valid !== '0 || busy !== 1'b0 || data_r !== '0 || addr_err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: valid %b busy %b data %h err %b expected all 0", valid, busy, data_r, addr_err);
    end
    tick; tick;
    rst_in = 1'b0;
    repeat (8) tick;
    checks++; if (q_cyc.size() !== 0) begin errors++; $display("FAIL aborted_valid: got %0d pulses expected 0", q_cyc.size()); end
    do_op(0, 4, 1'b0, '0, lat, m, rd, e);
    checks++; if (lat !== LAT || m !== 3'b001 || rd !== fill_val(4)) begin errors++; $display("FAIL post_reset_op: lat %0d mask %b data %h expected 4 001 %h", lat, m, rd, fill_val(4)); end
    $display("post-reset read lat %0d data %h", lat, rd);
  endtask

  task automatic test_readback;
    int lat; logic [NR-1:0] m; logic [EW-1:0] rd; logic e;
    logic [EW-1:0] exp;
    for (int a = 0; a < DEPTH; a++) begin
      exp = (a == 3) ? {16'd100, 16'd5} : fill_val(a);
      do_op(1, a, 1'b0, '0, lat, m, rd, e);
      checks++;
      if (rd !== exp || lat !== LAT || m !== 3'b010 || e !== 1'b0) begin
        errors++;
        $display("FAIL readback_%0d: data %h lat %0d mask %b err %b expected %h 4 010 0", a, rd, lat, m, e, exp);
      end
      $display("readback addr %0d data %h", a, rd);
    end
  endtask

  initial begin
    test_reset;
    test_fill;
    test_write_read;
    test_contention;
    test_fairness;
    test_out_of_range;
    test_duplicate;
    test_reset_mid_access;
    test_readback;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
